// File: rtl/sipo_reg_loader.sv
// Serial frame receiver that turns {start, addr[2:0], data[7:0], optional even parity}
// into a single-cycle register-file write, rejecting bad parity and writes to address 0.
module sipo_reg_loader #(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  input  logic       sin_valid,
  output logic [2:0] addrw,
  output logic [7:0] data_out,
  output logic       write,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    PAR    = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [2:0]  addr_reg;
  logic [7:0]  data_reg;
  logic        par_reg;

  logic        frame_done;
  logic        bad_parity;
  logic        accept;
  logic [7:0]  data_final;

  // The commit decision is taken on the edge that samples the last bit, so the
  // registered strobes line up with the single COMMIT cycle.
  always_comb begin
    frame_done = 1'b0;
    bad_parity = 1'b0;
    data_final = data_reg;
    if (sin_valid) begin
      if (state_reg == DATA && cnt_reg == 4'd7 && !PARITY_EN) begin
        frame_done = 1'b1;
        data_final = {data_reg[6:0], sin};
      end else if (state_reg == PAR) begin
        frame_done = 1'b1;
        bad_parity = par_reg ^ sin;
      end
    end
    accept = frame_done && !bad_parity && (addr_reg != 3'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 3'd0;
      data_reg  <= 8'd0;
      par_reg   <= 1'b0;
      addrw     <= 3'd0;
      data_out  <= 8'd0;
      write     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      write     <= 1'b0;
      frame_err <= 1'b0;

      if (frame_done) begin
        if (accept) begin
          write    <= 1'b1;
          addrw    <= addr_reg;
          data_out <= data_final;
        end else begin
          frame_err <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (sin_valid && sin) begin
            state_reg <= ADDR;
            cnt_reg   <= 4'd0;
            addr_reg  <= 3'd0;
            data_reg  <= 8'd0;
            par_reg   <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ADDR: begin
          if (sin_valid) begin
            addr_reg <= {addr_reg[1:0], sin};
            par_reg  <= par_reg ^ sin;
            if (cnt_reg == 4'd2) begin
              state_reg <= DATA;
              cnt_reg   <= 4'd0;
            end else begin
              cnt_reg <= cnt_reg + 4'd1;
            end
          end
        end
        DATA: begin
          if (sin_valid) begin
            data_reg <= {data_reg[6:0], sin};
            par_reg  <= par_reg ^ sin;
            if (cnt_reg == 4'd7) begin
              state_reg <= PARITY_EN ? PAR : COMMIT;
              cnt_reg   <= 4'd0;
            end else begin
              cnt_reg <= cnt_reg + 4'd1;
            end
          end
        end
        PAR: begin
          if (sin_valid) begin
            state_reg <= COMMIT;
            cnt_reg   <= 4'd0;
          end
        end
        COMMIT: begin
          state_reg <= IDLE;
          cnt_reg   <= 4'd0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= 4'd0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_reg_loader.sv
// Directed bench for sipo_reg_loader: one instance with parity, one without.
module tb_sipo_reg_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin1 = 1'b0, v1 = 1'b0;
  logic       sin0 = 1'b0, v0 = 1'b0;
  logic [2:0] addrw1, addrw0;
  logic [7:0] data1, data0;
  logic       wr1, wr0, busy1, busy0, fe1, fe0;

  int total = 0;
  int bad = 0;
  int wr_cnt1 = 0, fe_cnt1 = 0, wr_cnt0 = 0, fe_cnt0 = 0, busy_cnt0 = 0;

  sipo_reg_loader #(.PARITY_EN(1'b1)) dut_par (
    .clk(clk), .rst_n(rst_n), .sin(sin1), .sin_valid(v1),
    .addrw(addrw1), .data_out(data1), .write(wr1), .busy(busy1), .frame_err(fe1)
  );

  sipo_reg_loader #(.PARITY_EN(1'b0)) dut_nopar (
    .clk(clk), .rst_n(rst_n), .sin(sin0), .sin_valid(v0),
    .addrw(addrw0), .data_out(data0), .write(wr0), .busy(busy0), .frame_err(fe0)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr1) wr_cnt1++;
    if (fe1) fe_cnt1++;
    if (wr0) wr_cnt0++;
    if (fe0) fe_cnt0++;
    if (busy0) busy_cnt0++;
  end

  task automatic drive(input int which, input logic b, input logic v);
    if (which == 1) begin
      sin1 = b;
      v1   = v;
    end else begin
      sin0 = b;
      v0   = v;
    end
  endtask

  // Sends bits[n-1] .. bits[0], with 'gap' invalid cycles (random sin) before each bit.
  // Returns at the falling edge after the last bit was sampled.
  task automatic send(input int which, input logic [31:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        drive(which, 1'($urandom_range(0, 1)), 1'b0);
      end
      @(negedge clk);
      drive(which, bits[i], 1'b1);
    end
    @(negedge clk);
    drive(which, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (addrw1 !== 3'd0)  begin bad++; $display("FAIL reset_addrw got=%0d want=0", addrw1); end
    total++; if (data1 !== 8'h00)  begin bad++; $display("FAIL reset_data got=%02h want=00", data1); end
    total++; if (wr1 !== 1'b0)     begin bad++; $display("FAIL reset_write got=%0b want=0", wr1); end
    total++; if (busy1 !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%0b want=0", busy1); end
    total++; if (fe1 !== 1'b0)     begin bad++; $display("FAIL reset_ferr got=%0b want=0", fe1); end
    total++; if (busy0 !== 1'b0 || wr0 !== 1'b0) begin bad++; $display("FAIL reset_nopar got busy=%0b wr=%0b want 0/0", busy0, wr0); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (wr1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL release_quiet got wr=%0b busy=%0b want 0/0", wr1, busy1); end
    $display("reset: addrw=%0d data=%02h busy=%0b", addrw1, data1, busy1);
  endtask

  task automatic test_idle_ignore;
    send(1, 32'h0, 4, 0);
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL idle_zeros_busy got=%0b want=0", busy1); end
    total++; if (fe1 !== 1'b0)   begin bad++; $display("FAIL idle_zeros_ferr got=%0b want=0", fe1); end
    $display("idle zeros: busy=%0b", busy1);
  endtask

  task automatic test_good_frame;
    send(1, 32'd1, 1, 0);
    total++; if (busy1 !== 1'b1 || wr1 !== 1'b0) begin bad++; $display("FAIL start_busy got busy=%0b wr=%0b want 1/0", busy1, wr1); end
    send(1, 32'b101_10100111_1, 12, 0);
    total++; if (wr1 !== 1'b1)     begin bad++; $display("FAIL good_write got=%0b want=1", wr1); end
    total++; if (addrw1 !== 3'd5)  begin bad++; $display("FAIL good_addrw got=%0d want=5", addrw1); end
    total++; if (data1 !== 8'hA7)  begin bad++; $display("FAIL good_data got=%02h want=a7", data1); end
    total++; if (busy1 !== 1'b1 || fe1 !== 1'b0) begin bad++; $display("FAIL good_commit got busy=%0b ferr=%0b want 1/0", busy1, fe1); end
    $display("frame good: write=%0b addrw=%0d data=%02h", wr1, addrw1, data1);
    @(negedge clk);
    total++; if (wr1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL good_after got wr=%0b busy=%0b want 0/0", wr1, busy1); end
    total++; if (addrw1 !== 3'd5 || data1 !== 8'hA7) begin bad++; $display("FAIL good_hold got %0d/%02h want 5/a7", addrw1, data1); end
  endtask

  task automatic test_parity_error;
    int w0, f0;
    #1; w0 = wr_cnt1; f0 = fe_cnt1;
    send(1, 32'b1_101_10100111_0, 13, 0);
    total++; if (wr1 !== 1'b0 || fe1 !== 1'b1) begin bad++; $display("FAIL par_commit got wr=%0b ferr=%0b want 0/1", wr1, fe1); end
    total++; if (addrw1 !== 3'd5 || data1 !== 8'hA7) begin bad++; $display("FAIL par_hold got %0d/%02h want 5/a7", addrw1, data1); end
    $display("frame bad parity: write=%0b ferr=%0b", wr1, fe1);
    @(negedge clk); #1;
    total++; if (fe1 !== 1'b0) begin bad++; $display("FAIL par_pulse got=%0b want=0", fe1); end
    total++; if (wr_cnt1 - w0 !== 0 || fe_cnt1 - f0 !== 1) begin bad++; $display("FAIL par_counts got wr=%0d ferr=%0d want 0/1", wr_cnt1 - w0, fe_cnt1 - f0); end
  endtask

  task automatic test_addr_zero;
    send(1, 32'b1_000_01010101_0, 13, 0);
    total++; if (wr1 !== 1'b0 || fe1 !== 1'b1) begin bad++; $display("FAIL addr0_commit got wr=%0b ferr=%0b want 0/1", wr1, fe1); end
    total++; if (addrw1 !== 3'd5 || data1 !== 8'hA7) begin bad++; $display("FAIL addr0_hold got %0d/%02h want 5/a7", addrw1, data1); end
    $display("frame addr0: write=%0b ferr=%0b", wr1, fe1);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int w0, f0;
    logic [31:0] s;
    s = {5'b0, 13'b1_111_11111111_1, 1'b1, 13'b1_010_00110011_1};
    #1; w0 = wr_cnt1; f0 = fe_cnt1;
    send(1, s, 27, 0);
    total++; if (wr1 !== 1'b1)    begin bad++; $display("FAIL b2b_write got=%0b want=1", wr1); end
    total++; if (addrw1 !== 3'd2 || data1 !== 8'h33) begin bad++; $display("FAIL b2b_data got %0d/%02h want 2/33", addrw1, data1); end
    $display("frame back-to-back: write=%0b addrw=%0d data=%02h", wr1, addrw1, data1);
    @(negedge clk); #1;
    total++; if (wr_cnt1 - w0 !== 2 || fe_cnt1 - f0 !== 0) begin bad++; $display("FAIL b2b_counts got wr=%0d ferr=%0d want 2/0", wr_cnt1 - w0, fe_cnt1 - f0); end
  endtask

  task automatic test_gapped;
    send(1, 32'b1_101_10100111_1, 13, 2);
    total++; if (wr1 !== 1'b1)    begin bad++; $display("FAIL gap_write got=%0b want=1", wr1); end
    total++; if (addrw1 !== 3'd5 || data1 !== 8'hA7) begin bad++; $display("FAIL gap_data got %0d/%02h want 5/a7", addrw1, data1); end
    $display("frame gapped: write=%0b addrw=%0d data=%02h", wr1, addrw1, data1);
    @(negedge clk);
    total++; if (wr1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL gap_after got wr=%0b busy=%0b want 0/0", wr1, busy1); end
  endtask

  task automatic test_reset_mid_frame;
    int w0, f0;
    send(1, 32'b1_111_11, 6, 0);
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL mid_busy got=%0b want=1", busy1); end
    #2; rst_n = 1'b0;
    #1;
    total++; if (busy1 !== 1'b0 || wr1 !== 1'b0 || fe1 !== 1'b0) begin bad++; $display("FAIL async_reset got busy=%0b wr=%0b ferr=%0b want 0/0/0", busy1, wr1, fe1); end
    total++; if (addrw1 !== 3'd0 || data1 !== 8'h00) begin bad++; $display("FAIL async_clear got %0d/%02h want 0/00", addrw1, data1); end
    w0 = wr_cnt1; f0 = fe_cnt1;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL post_release_busy got=%0b want=0", busy1); end
    send(1, 32'b1_111_11111111_1, 13, 0);
    total++; if (wr1 !== 1'b1)    begin bad++; $display("FAIL mid_new_write got=%0b want=1", wr1); end
    total++; if (addrw1 !== 3'd7 || data1 !== 8'hFF) begin bad++; $display("FAIL mid_new_data got %0d/%02h want 7/ff", addrw1, data1); end
    $display("frame after reset: write=%0b addrw=%0d data=%02h", wr1, addrw1, data1);
    @(negedge clk); #1;
    total++; if (wr_cnt1 - w0 !== 1 || fe_cnt1 - f0 !== 0) begin bad++; $display("FAIL mid_counts got wr=%0d ferr=%0d want 1/0", wr_cnt1 - w0, fe_cnt1 - f0); end
  endtask

  task automatic test_no_parity;
    int f0;
    @(negedge clk); #1;
    busy_cnt0 = 0; f0 = fe_cnt0;
    send(0, 32'b1_011_00001111, 12, 0);
    total++; if (wr0 !== 1'b1)    begin bad++; $display("FAIL nopar_write got=%0b want=1", wr0); end
    total++; if (addrw0 !== 3'd3 || data0 !== 8'h0F) begin bad++; $display("FAIL nopar_data got %0d/%02h want 3/0f", addrw0, data0); end
    $display("frame no parity: write=%0b addrw=%0d data=%02h", wr0, addrw0, data0);
    @(negedge clk); #1;
    total++; if (wr0 !== 1'b0 || busy0 !== 1'b0) begin bad++; $display("FAIL nopar_after got wr=%0b busy=%0b want 0/0", wr0, busy0); end
    total++; if (busy_cnt0 !== 12) begin bad++; $display("FAIL nopar_busy_len got=%0d want=12", busy_cnt0); end
    total++; if (fe_cnt0 - f0 !== 0) begin bad++; $display("FAIL nopar_ferr got=%0d want=0", fe_cnt0 - f0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_good_frame();
    test_parity_error();
    test_addr_zero();
    test_back_to_back();
    test_gapped();
    test_reset_mid_frame();
    test_no_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
